// File: rtl/bcd_stopwatch_counter.sv
// Two-digit BCD run/pause counter with start/stop and clear pushbuttons.
// Steps once per divider tick while running and wraps at a programmable modulo.
module bcd_stopwatch_counter #(
  parameter int unsigned MODULO     = 60,
  parameter int unsigned SYNC_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       up_down,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       running,
  output logic       wrap
);

  localparam int unsigned MAX_VAL = MODULO - 1;
  localparam logic [3:0]  MAX_T   = 4'(MAX_VAL / 10);
  localparam logic [3:0]  MAX_U   = 4'(MAX_VAL % 10);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t                state;
  logic [SYNC_DEPTH-1:0] ss_sync;
  logic [SYNC_DEPTH-1:0] clr_sync;
  logic                  ss_prev;
  logic                  clr_prev;
  logic                  ss_p;
  logic                  clr_p;

  // Pushbutton synchronisers followed by rising-edge detectors
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ss_sync  <= '0;
      clr_sync <= '0;
      ss_prev  <= 1'b0;
      clr_prev <= 1'b0;
    end else begin
      ss_sync  <= {ss_sync[SYNC_DEPTH-2:0], btn_start_stop};
      clr_sync <= {clr_sync[SYNC_DEPTH-2:0], btn_clear};
      ss_prev  <= ss_sync[SYNC_DEPTH-1];
      clr_prev <= clr_sync[SYNC_DEPTH-1];
    end
  end

  assign ss_p  = ss_sync[SYNC_DEPTH-1] & ~ss_prev;
  assign clr_p = clr_sync[SYNC_DEPTH-1] & ~clr_prev;

  // Control FSM and BCD digit datapath; clear overrides start/stop and tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      units   <= 4'd0;
      tens    <= 4'd0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_p) begin
        state   <= IDLE;
        units   <= 4'd0;
        tens    <= 4'd0;
        running <= 1'b0;
      end else begin
        // Step decision uses the pre-edge state, so leaving RUN still counts
        if (state == RUN && tick) begin
          if (up_down) begin
            if (tens == MAX_T && units == MAX_U) begin
              tens  <= 4'd0;
              units <= 4'd0;
              wrap  <= 1'b1;
            end else if (units == 4'd9) begin
              units <= 4'd0;
              tens  <= tens + 4'd1;
            end else begin
              units <= units + 4'd1;
            end
          end else begin
            if (tens == 4'd0 && units == 4'd0) begin
              tens  <= MAX_T;
              units <= MAX_U;
              wrap  <= 1'b1;
            end else if (units == 4'd0) begin
              units <= 4'd9;
              tens  <= tens - 4'd1;
            end else begin
              units <= units - 4'd1;
            end
          end
        end
        if (ss_p) begin
          case (state)
            IDLE: begin
              state   <= RUN;
              running <= 1'b1;
            end
            RUN: begin
              state   <= PAUSE;
              running <= 1'b0;
            end
            PAUSE: begin
              state   <= RUN;
              running <= 1'b1;
            end
            default: begin
              state   <= IDLE;
              running <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Directed bench for bcd_stopwatch_counter: MODULO=60 and MODULO=100 instances
// share stimulus; each scenario task checks its own expected values.
module tb_bcd_stopwatch_counter;

  localparam int SD = 2;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       up_down;
  logic [3:0] u60, t60, u100, t100;
  logic       r60, w60, r100, w100;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_stopwatch_counter #(.MODULO(60), .SYNC_DEPTH(SD)) dut60 (
    .clock(clock), .reset(reset), .tick(tick),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .up_down(up_down),
    .units(u60), .tens(t60), .running(r60), .wrap(w60)
  );

  bcd_stopwatch_counter #(.MODULO(100), .SYNC_DEPTH(SD)) dut100 (
    .clock(clock), .reset(reset), .tick(tick),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .up_down(up_down),
    .units(u100), .tens(t100), .running(r100), .wrap(w100)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic press_ss();
    btn_start_stop = 1'b1;
    repeat (SD + 1) cyc();
    btn_start_stop = 1'b0;
    repeat (SD + 1) cyc();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic test_reset_values();
    n_cmp++;
    if ({t60, u60, r60, w60} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_values60: got %h expected 000", {t60, u60, r60, w60});
    end
    n_cmp++;
    if ({t100, u100, r100, w100} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_values100: got %h expected 000", {t100, u100, r100, w100});
    end
  endtask

  task automatic test_reset();
    press_ss();
    ticks(37);
    n_cmp++;
    if ({t60, u60} !== 8'h37) begin
      n_bad++;
      $display("FAIL reset_pre37: got %h expected 37", {t60, u60});
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({t60, u60, r60} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_async: got %h expected 000", {t60, u60, r60});
    end
    cyc();
    reset = 1'b0;
    ticks(5);
    n_cmp++;
    if ({t60, u60, r60} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ticks_ignored: got %h expected 000", {t60, u60, r60});
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp;
    int v;
    btn_start_stop = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if (r60 !== 1'b0) begin
      n_bad++;
      $display("FAIL start_latency_early: got %b expected 0", r60);
    end
    cyc();
    n_cmp++;
    if (r60 !== 1'b1) begin
      n_bad++;
      $display("FAIL start_latency: got %b expected 1", r60);
    end
    btn_start_stop = 1'b0;
    repeat (SD + 1) cyc();
    for (int i = 0; i < 60; i++) begin
      tick = 1'b1;
      cyc();
      v = (i + 1) % 60;
      exp = {4'(v / 10), 4'(v % 10)};
      n_cmp++;
      if ({t60, u60, w60} !== {exp, (i == 59)}) begin
        n_bad++;
        $display("FAIL up_count step %0d: got %h/%b expected %h/%b",
                 i, {t60, u60}, w60, exp, (i == 59));
      end
    end
    tick = 1'b0;
    cyc();
    n_cmp++;
    if (w60 !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_one_clock: got %b expected 0", w60);
    end
  endtask

  task automatic test_carry_borrow();
    ticks(9);
    n_cmp++;
    if ({t60, u60} !== 8'h09) begin
      n_bad++;
      $display("FAIL carry_pre: got %h expected 09", {t60, u60});
    end
    ticks(1);
    n_cmp++;
    if ({t60, u60} !== 8'h10) begin
      n_bad++;
      $display("FAIL carry: got %h expected 10", {t60, u60});
    end
    up_down = 1'b0;
    ticks(1);
    n_cmp++;
    if ({t60, u60} !== 8'h09) begin
      n_bad++;
      $display("FAIL borrow: got %h expected 09", {t60, u60});
    end
    ticks(9);
    n_cmp++;
    if ({t60, u60, w60} !== 9'h000) begin
      n_bad++;
      $display("FAIL down_to_zero: got %h/%b expected 00/0", {t60, u60}, w60);
    end
    ticks(1);
    n_cmp++;
    if ({t60, u60, w60} !== {8'h59, 1'b1}) begin
      n_bad++;
      $display("FAIL down_wrap: got %h/%b expected 59/1", {t60, u60}, w60);
    end
    up_down = 1'b1;
  endtask

  task automatic test_pause_resume();
    ticks(13);
    n_cmp++;
    if ({t60, u60} !== 8'h12) begin
      n_bad++;
      $display("FAIL pause_pre12: got %h expected 12", {t60, u60});
    end
    press_ss();
    ticks(5);
    n_cmp++;
    if ({t60, u60, r60} !== {8'h12, 1'b0}) begin
      n_bad++;
      $display("FAIL paused: got %h/%b expected 12/0", {t60, u60}, r60);
    end
    press_ss();
    n_cmp++;
    if (r60 !== 1'b1) begin
      n_bad++;
      $display("FAIL resume_running: got %b expected 1", r60);
    end
    ticks(1);
    n_cmp++;
    if ({t60, u60} !== 8'h13) begin
      n_bad++;
      $display("FAIL resume_count: got %h expected 13", {t60, u60});
    end
  endtask

  task automatic test_simultaneous();
    ticks(12);
    n_cmp++;
    if ({t60, u60} !== 8'h25) begin
      n_bad++;
      $display("FAIL simul_pre25: got %h expected 25", {t60, u60});
    end
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    cyc();
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    n_cmp++;
    if ({t60, u60, r60, w60} !== 10'd0) begin
      n_bad++;
      $display("FAIL simul_clear: got %h/%b/%b expected 00/0/0", {t60, u60}, r60, w60);
    end
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    repeat (SD + 1) cyc();
    ticks(3);
    n_cmp++;
    if ({t60, u60, r60} !== 9'd0) begin
      n_bad++;
      $display("FAIL simul_idle: got %h/%b expected 00/0", {t60, u60}, r60);
    end
  endtask

  task automatic test_modulo100();
    btn_start_stop = 1'b1;
    repeat (100) cyc();
    n_cmp++;
    if (r100 !== 1'b1) begin
      n_bad++;
      $display("FAIL held_one_toggle: got %b expected 1", r100);
    end
    btn_start_stop = 1'b0;
    repeat (SD + 1) cyc();
    n_cmp++;
    if (r100 !== 1'b1) begin
      n_bad++;
      $display("FAIL held_release: got %b expected 1", r100);
    end
    ticks(99);
    n_cmp++;
    if ({t100, u100, w100} !== {8'h99, 1'b0}) begin
      n_bad++;
      $display("FAIL m100_at99: got %h/%b expected 99/0", {t100, u100}, w100);
    end
    ticks(1);
    n_cmp++;
    if ({t100, u100, w100} !== {8'h00, 1'b1}) begin
      n_bad++;
      $display("FAIL m100_wrap: got %h/%b expected 00/1", {t100, u100}, w100);
    end
    cyc();
    n_cmp++;
    if (w100 !== 1'b0) begin
      n_bad++;
      $display("FAIL m100_wrap_clear: got %b expected 0", w100);
    end
  endtask

  initial begin
    reset          = 1'b1;
    tick           = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    up_down        = 1'b1;
    cyc();
    cyc();
    test_reset_values();
    reset = 1'b0;
    cyc();
    test_reset();
    test_up_wrap();
    test_carry_borrow();
    test_pause_resume();
    test_simultaneous();
    test_modulo100();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
